// File: rtl/m16_bank_write_arb_if.sv
// Interface for the m16 bank write arbiter: the two producer write ports,
// the serializer bank-select input, the RAM write port and frame status.
// The arbiter takes the slave view; the producers, the serializer and the
// RAM together take the master view.
interface m16_bank_write_arb_if #(
  parameter int AW = 11,
  parameter int DW = 12
);
  logic          iSwitch;
  logic          iReqA;
  logic [AW-1:0] iAddrA;
  logic [DW-1:0] iDataA;
  logic          oAckA;
  logic          iReqB;
  logic [AW-1:0] iAddrB;
  logic [DW-1:0] iDataB;
  logic          oAckB;
  logic [AW:0]   oWrAddr;
  logic [DW-1:0] oWrData;
  logic          oWrEn;
  logic          oFrameStart;
  logic [AW:0]   oCntWr;
  logic [AW:0]   oLastCnt;
  logic          oOvf;

  modport slave (
    input  iSwitch, iReqA, iAddrA, iDataA, iReqB, iAddrB, iDataB,
    output oAckA, oAckB, oWrAddr, oWrData, oWrEn, oFrameStart,
           oCntWr, oLastCnt, oOvf
  );

  modport master (
    output iSwitch, iReqA, iAddrA, iDataA, iReqB, iAddrB, iDataB,
    input  oAckA, oAckB, oWrAddr, oWrData, oWrEn, oFrameStart,
           oCntWr, oLastCnt, oOvf
  );
endinterface

// File: rtl/m16_bank_write_arb.sv
// Write-side controller for the ping-pong telemetry RAM. Two producers share
// the single RAM write port through a round-robin arbiter; every write goes
// to the bank the orbit serializer is not reading. Bank switches mark frame
// boundaries, at which the per-frame write count is latched and cleared.
// Writes beyond FRAME_WORDS in one frame are acknowledged but dropped, and
// flagged through a sticky per-frame overflow bit.
module m16_bank_write_arb #(
  parameter int AW          = 11,
  parameter int DW          = 12,
  parameter int FRAME_WORDS = 2048
) (
  input  logic               iClk,
  input  logic               reset,
  m16_bank_write_arb_if.slave bus
);

  localparam logic [AW:0] FULL = (AW+1)'(FRAME_WORDS);

  // Frame write counter step, pinned at FULL.
  function automatic logic [AW:0] satInc(input logic [AW:0] cnt);
    return (cnt >= FULL) ? cnt : cnt + 1'b1;
  endfunction

  logic swReg;
  logic reqA_p0;
  logic reqB_p0;
  logic lastB;

  logic edgeDet;
  logic eligA;
  logic eligB;
  logic grantA;
  logic grantB;
  logic grantAny;
  logic full;

  // Arbitration decision: a bank switch blocks grants for one cycle; a
  // requester acked last cycle sits out one cycle so it can drop its request,
  // and a request withdrawn before its grant is simply not served.
  always_comb begin
    edgeDet  = bus.iSwitch != swReg;
    eligA    = reqA_p0 & bus.iReqA & ~bus.oAckA;
    eligB    = reqB_p0 & bus.iReqB & ~bus.oAckB;
    grantA   = ~edgeDet & eligA & (~eligB | lastB);
    grantB   = ~edgeDet & eligB & (~eligA | ~lastB);
    grantAny = grantA | grantB;
    full     = bus.oCntWr >= FULL;
  end

  // Stage p0: sample the serializer bank select and the producer requests.
  always_ff @(posedge iClk or posedge reset) begin
    if (reset) begin
      swReg   <= 1'b0;
      reqA_p0 <= 1'b0;
      reqB_p0 <= 1'b0;
    end else begin
      swReg   <= bus.iSwitch;
      reqA_p0 <= bus.iReqA;
      reqB_p0 <= bus.iReqB;
    end
  end

  // Grant stage: acks, RAM write port, round-robin pointer and frame status.
  always_ff @(posedge iClk or posedge reset) begin
    if (reset) begin
      bus.oAckA       <= 1'b0;
      bus.oAckB       <= 1'b0;
      bus.oWrEn       <= 1'b0;
      bus.oWrAddr     <= '0;
      bus.oWrData     <= '0;
      bus.oFrameStart <= 1'b0;
      bus.oCntWr      <= '0;
      bus.oLastCnt    <= '0;
      bus.oOvf        <= 1'b0;
      lastB           <= 1'b1;
    end else begin
      bus.oAckA       <= grantA;
      bus.oAckB       <= grantB;
      bus.oFrameStart <= edgeDet;
      bus.oWrEn       <= grantAny & ~full;
      if (grantAny) begin
        lastB <= grantB;
      end
      if (grantA) begin
        bus.oWrAddr <= {~swReg, bus.iAddrA};
        bus.oWrData <= bus.iDataA;
      end else if (grantB) begin
        bus.oWrAddr <= {~swReg, bus.iAddrB};
        bus.oWrData <= bus.iDataB;
      end
      if (edgeDet) begin
        bus.oLastCnt <= bus.oCntWr;
        bus.oCntWr   <= '0;
        bus.oOvf     <= 1'b0;
      end else if (grantAny) begin
        if (full) begin
          bus.oOvf <= 1'b1;
        end else begin
          bus.oCntWr <= satInc(bus.oCntWr);
        end
      end
    end
  end

endmodule

// File: tb/tb_m16_bank_write_arb.sv
// Bench for m16_bank_write_arb: directed scenarios followed by randomized
// producer / bank-switch / reset traffic, checked every cycle against a
// transaction-level reference model of the arbiter.
module tb_m16_bank_write_arb;
  localparam int AW = 11;
  localparam int DW = 12;
  localparam int FW = 2048;

  logic iClk = 1'b0;
  logic reset;
  always #5 iClk = ~iClk;

  m16_bank_write_arb_if #(.AW(AW), .DW(DW)) bus ();

  m16_bank_write_arb #(.AW(AW), .DW(DW), .FRAME_WORDS(FW)) dut (
    .iClk (iClk),
    .reset(reset),
    .bus  (bus)
  );

  // Bench-driven stimulus; index 0 is producer A, index 1 is producer B.
  logic          sw;
  logic          req  [2];
  logic [AW-1:0] addr [2];
  logic [DW-1:0] data [2];

  assign bus.iSwitch = sw;
  assign bus.iReqA   = req[0];
  assign bus.iAddrA  = addr[0];
  assign bus.iDataA  = data[0];
  assign bus.iReqB   = req[1];
  assign bus.iAddrB  = addr[1];
  assign bus.iDataB  = data[1];

  int total = 0;
  int bad   = 0;
  string phase = "reset";

  // Reference model state.
  logic          mSw;
  logic          mSeen [2];
  logic          mAck  [2];
  int            mLast;
  logic          mWrEn;
  logic [AW:0]   mWrAddr;
  logic [DW-1:0] mWrData;
  logic          mFs;
  int            mCnt;
  int            mLastCnt;
  logic          mOvf;

  task automatic mReset();
    mSw = 1'b0;
    for (int p = 0; p < 2; p++) begin
      mSeen[p] = 1'b0;
      mAck[p]  = 1'b0;
    end
    mLast    = 1;
    mWrEn    = 1'b0;
    mWrAddr  = '0;
    mWrData  = '0;
    mFs      = 1'b0;
    mCnt     = 0;
    mLastCnt = 0;
    mOvf     = 1'b0;
  endtask

  // One clock edge of the reference: frame boundary, eligibility,
  // round robin, bank steering and frame accounting.
  task automatic mStep();
    logic boundary;
    logic bank;
    logic elig [2];
    int   win;
    boundary = (sw != mSw);
    bank     = ~mSw;
    for (int p = 0; p < 2; p++) elig[p] = req[p] && mSeen[p] && !mAck[p];
    win = -1;
    if (!boundary) begin
      if (elig[0] && elig[1]) win = 1 - mLast;
      else if (elig[0])       win = 0;
      else if (elig[1])       win = 1;
    end
    mAck[0] = (win == 0);
    mAck[1] = (win == 1);
    mFs     = boundary;
    mWrEn   = 1'b0;
    if (boundary) begin
      mLastCnt = mCnt;
      mCnt     = 0;
      mOvf     = 1'b0;
    end
    if (win >= 0) begin
      mLast   = win;
      mWrAddr = {bank, addr[win]};
      mWrData = data[win];
      if (mCnt < FW) begin
        mWrEn = 1'b1;
        mCnt  = mCnt + 1;
      end else begin
        mOvf = 1'b1;
      end
    end
    mSw = sw;
    for (int p = 0; p < 2; p++) mSeen[p] = req[p];
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    chk("ackA",     32'(bus.oAckA),       32'(mAck[0]));
    chk("ackB",     32'(bus.oAckB),       32'(mAck[1]));
    chk("wrEn",     32'(bus.oWrEn),       32'(mWrEn));
    chk("wrAddr",   32'(bus.oWrAddr),     32'(mWrAddr));
    chk("wrData",   32'(bus.oWrData),     32'(mWrData));
    chk("frmStart", 32'(bus.oFrameStart), 32'(mFs));
    chk("cntWr",    32'(bus.oCntWr),      32'(mCnt));
    chk("lastCnt",  32'(bus.oLastCnt),    32'(mLastCnt));
    chk("ovf",      32'(bus.oOvf),        32'(mOvf));
  endtask

  task automatic step();
    @(posedge iClk);
    mStep();
    #1;
    checkAll();
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic doReset();
    reset = 1'b1;
    #2;
    mReset();
    checkAll();
    @(posedge iClk);
    #1;
    checkAll();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    sw    = 1'b0;
    for (int p = 0; p < 2; p++) begin
      req[p]  = 1'b0;
      addr[p] = '0;
      data[p] = '0;
    end
    mReset();
    #1;
    checkAll();
    @(posedge iClk);
    #1;
    doReset();

    // Single A write into bank 1 while the serializer reads bank 0.
    phase   = "single";
    req[0]  = 1'b1;
    addr[0] = 11'd5;
    data[0] = 12'hABC;
    step();
    step();
    chk("ackA", 32'(bus.oAckA), 32'd1);
    chk("addr", 32'(bus.oWrAddr), 32'h805);
    chk("data", 32'(bus.oWrData), 32'hABC);
    chk("cnt",  32'(bus.oCntWr), 32'd1);
    req[0] = 1'b0;
    step();
    step();

    // Both producers held continuously: alternating grants.
    phase   = "alt";
    req[0]  = 1'b1; addr[0] = 11'h010; data[0] = 12'h111;
    req[1]  = 1'b1; addr[1] = 11'h020; data[1] = 12'h222;
    for (int i = 0; i < 10; i++) step();
    req[0] = 1'b0;
    req[1] = 1'b0;
    step();
    step();

    // Bank switch in the same cycle A requests.
    phase   = "switch";
    req[0]  = 1'b1; addr[0] = 11'h033; data[0] = 12'h5A5;
    sw      = 1'b1;
    step();
    chk("ackA", 32'(bus.oAckA), 32'd0);
    chk("fs",   32'(bus.oFrameStart), 32'd1);
    chk("cnt",  32'(bus.oCntWr), 32'd0);
    step();
    chk("ackA", 32'(bus.oAckA), 32'd1);
    chk("bank", 32'(bus.oWrAddr[AW]), 32'd0);
    req[0] = 1'b0;
    step();
    step();

    // Fill a whole frame, then one more request overflows.
    phase  = "fill";
    req[0] = 1'b1;
    req[1] = 1'b1;
    for (int i = 0; i < 5000 && mCnt < FW; i++) begin
      step();
      addr[0] = AW'($urandom);
      data[0] = DW'($urandom);
      addr[1] = AW'($urandom);
      data[1] = DW'($urandom);
    end
    chk("fullCnt", 32'(bus.oCntWr), 32'(FW));
    step();
    chk("ovfAck", 32'(bus.oAckA | bus.oAckB), 32'd1);
    chk("ovfWrEn", 32'(bus.oWrEn), 32'd0);
    chk("ovfFlag", 32'(bus.oOvf), 32'd1);
    chk("ovfCnt", 32'(bus.oCntWr), 32'(FW));
    req[0] = 1'b0;
    req[1] = 1'b0;
    sw     = 1'b0;
    step();
    chk("newOvf",  32'(bus.oOvf), 32'd0);
    chk("lastCnt", 32'(bus.oLastCnt), 32'(FW));
    step();

    // Reset while B waits for its grant; B is served once after release.
    phase   = "rstB";
    req[1]  = 1'b1; addr[1] = 11'h4C2; data[1] = 12'h3C3;
    step();
    doReset();
    step();
    step();
    chk("ackB", 32'(bus.oAckB), 32'd1);
    chk("bank", 32'(bus.oWrAddr[AW]), 32'd1);
    chk("cnt",  32'(bus.oCntWr), 32'd1);
    req[1] = 1'b0;
    step();
    step();
    chk("noDup", 32'(bus.oCntWr), 32'd1);

    // B withdraws its request before it is granted.
    phase  = "dropB";
    req[1] = 1'b1; addr[1] = 11'h100; data[1] = 12'h0F0;
    step();
    req[1] = 1'b0;
    step();
    chk("ackB", 32'(bus.oAckB), 32'd0);
    chk("wrEn", 32'(bus.oWrEn), 32'd0);
    chk("cnt",  32'(bus.oCntWr), 32'd1);
    step();

    // Randomized producers, bank switches and occasional resets.
    phase = "random";
    for (int i = 0; i < 3000; i++) begin
      step();
      for (int p = 0; p < 2; p++) begin
        if (req[p] && mAck[p]) begin
          req[p] = 1'b0;
        end else if (req[p] && $urandom_range(0, 39) == 0) begin
          req[p] = 1'b0;
        end else if (!req[p] && $urandom_range(0, 2) == 0) begin
          req[p]  = 1'b1;
          addr[p] = AW'($urandom);
          data[p] = DW'($urandom);
        end
      end
      if ($urandom_range(0, 149) == 0) sw = ~sw;
      if ($urandom_range(0, 999) == 0) doReset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/m16_bank_write_arb.md
Name: m16_bank_write_arb

Overview:
- Write-side controller for the 2x2048-word ping-pong telemetry RAM drained by the orbit serializer.
- Arbitrates two word producers (A: fast ADC channel, B: slow LCB channel) onto the single RAM write port.
- Steers every write into the bank the serializer is not reading, tracks frame boundaries from the serializer's bank-switch signal, and flags per-frame overflow.

Parameters:
- AW, 11, word address width inside one bank (2048 words)
- DW, 12, data word width
- FRAME_WORDS, 2048, writes accepted per frame before overflow

Ports:
- iClk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- iSwitch  in  1  bank currently read by serializer; same clock domain
- iReqA  in  1  producer A write request; level, held until oAckA
- iAddrA  in  AW  producer A word address within bank
- iDataA  in  DW  producer A data
- oAckA  out  1  one-cycle grant/accept pulse to A
- iReqB  in  1  producer B write request
- iAddrB  in  AW  producer B word address
- iDataB  in  DW  producer B data
- oAckB  out  1  one-cycle grant/accept pulse to B
- oWrAddr  out  AW+1  RAM write address; MSB = bank, low AW = word address
- oWrData  out  DW  RAM write data
- oWrEn  out  1  RAM write strobe
- oFrameStart  out  1  one-cycle pulse on each bank switch
- oCntWr  out  AW+1  writes committed in current frame, saturates at FRAME_WORDS
- oLastCnt  out  AW+1  oCntWr value latched at the last frame boundary
- oOvf  out  1  sticky per frame: a request was accepted while the frame was full

Behaviour:
- Reset (async, high): all outputs 0; swReg=0; last-served pointer=B, so A wins the first tie; hold-off flags cleared.
- swReg registers iSwitch each cycle. Edge = iSwitch != swReg. Write bank = ~swReg.
- Frame boundary (edge cycle):
  - Next cycle: oFrameStart=1, oLastCnt<=oCntWr, oCntWr<=0, oOvf<=0.
  - No grant is issued in the edge cycle. Pending requests stay pending and are granted afterwards into the new bank.
- Eligibility: requester X is eligible when iReqX=1 and X was not acked in the previous cycle. The one-cycle hold-off lets the producer drop its request after ack.
- Arbitration (round-robin):
  - One grant per cycle.
  - Only one eligible requester: it wins.
  - Both eligible: the requester not served last wins.
  - The pointer updates on every grant.
- Latency: request sampled at edge t; at edge t+1, oAckX=1, oWrEn=1, oWrAddr={~swReg, iAddrX}, oWrData=iDataX. Address and data are captured at edge t+1 (t+1 = the grant edge), so producers hold them until ack.
- Full frame: once oCntWr==FRAME_WORDS, grants still produce oAckX=1 but oWrEn=0, and oOvf<=1. oCntWr holds.
- oCntWr increments by 1 per oWrEn, saturating at FRAME_WORDS (12-bit, max 2048).
- Simultaneous edge and request: the edge wins; no ack in that cycle.
- Edge arriving with oCntWr mid-count: count is latched and cleared as above. The write already in flight (oWrEn this cycle) targets the old bank and is included in oLastCnt.
- Requester dropping iReq before ack: no grant; no error.
- Reset mid-operation: immediate clear of all outputs. After release, the first edge is detected relative to swReg=0.

Test Plan:
- Reset then iSwitch=0, A requests addr 5 data 0xABC → 2 cycles later oAckA=1, oWrEn=1, oWrAddr=0x805, oWrData=0xABC, oCntWr=1.
- A and B held continuously → acks alternate A,B,A,B. Each requester sees at most one ack per two cycles. oCntWr increments every cycle.
- Toggle iSwitch 0→1 with A requesting in the same cycle → no ack that cycle; next cycle oFrameStart=1, oLastCnt=prior count, oCntWr=0. The following grant uses oWrAddr MSB=0.
- 2048 writes in one frame, then a 2049th request → oAckA=1, oWrEn=0, oOvf=1, oCntWr=2048. Next iSwitch toggle clears oOvf, and oLastCnt=2048.
- Assert reset while B is mid-handshake → all outputs 0 asynchronously. After release, B's held request is granted first with correct bank bit and no duplicate write.
- Producer drops iReqB one cycle before its grant would occur → no oAckB, no oWrEn, oCntWr unchanged.
